mmio_bus_fabric: RTL and testbench



---
 rtl/mmio_bus_fabric.sv | 229 ++++++++++++++++++++++
 tb/tb_mmio_bus_fabric.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_bus_fabric.sv
// Two-master, N-slave memory-mapped bus fabric: arbitration, region decode,
// req/ack slave handshake with timeout, and a registered response to the winner.
// Optional build macro ROUND_ROBIN_EN: round-robin arbitration instead of
// fixed priority (master 0 over master 1).
module mmio_bus_fabric #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned N_SLV  = 4,
  parameter logic [N_SLV*ADDR_W-1:0] SLV_BASE = {16'h4800, 16'h4400, 16'h2000, 16'h0000},
  parameter logic [N_SLV*5-1:0] SLV_SIZE_LOG2 = {5'd4, 5'd10, 5'd13, 5'd13},
  parameter int unsigned TIMEOUT = 15,
  parameter logic [DATA_W-1:0] ERR_DATA = 16'hDEAD
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              m_req,
  input  logic [1:0]              m_we,
  input  logic [2*ADDR_W-1:0]     m_addr,
  input  logic [2*DATA_W-1:0]     m_wdata,
  output logic [1:0]              m_ack,
  output logic                    m_err,
  output logic [DATA_W-1:0]       m_rdata,
  output logic [N_SLV-1:0]        s_sel,
  output logic                    s_we,
  output logic [ADDR_W-1:0]       s_addr,
  output logic [DATA_W-1:0]       s_wdata,
  input  logic [N_SLV*DATA_W-1:0] s_rdata,
  input  logic [N_SLV-1:0]        s_ack,
  output logic                    busy
);

  localparam int unsigned IDX_W = (N_SLV > 1) ? $clog2(N_SLV) : 1;
  localparam int unsigned CNT_W = 8;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              gnt_q, gnt_d;
  logic              we_q, we_d;
  logic              miss_q, miss_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [1:0]        m_ack_d;
  logic              m_err_d;
  logic [DATA_W-1:0] m_rdata_d;
  logic [N_SLV-1:0]  s_sel_d;
  logic              s_we_d;
  logic [ADDR_W-1:0] s_addr_d;
  logic [DATA_W-1:0] s_wdata_d;

  logic              win;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic              win_hit;
  logic [IDX_W-1:0]  win_idx;
  logic [ADDR_W-1:0] win_base;
  logic              ack_sel;
  logic [DATA_W-1:0] rdata_sel;

`ifdef ROUND_ROBIN_EN
  logic rr_q, rr_d;

  // Pick the winner: on contention the pointer names the favoured master
  always_comb begin
    if (m_req == 2'b11) win = rr_q;
    else                win = m_req[1] & ~m_req[0];
  end
`else
  // Pick the winner: master 0 always has priority
  always_comb begin
    win = ~m_req[0];
  end
`endif

  // Mux the winning master's request fields
  always_comb begin
    win_we    = win ? m_we[1] : m_we[0];
    win_addr  = win ? m_addr[2*ADDR_W-1 -: ADDR_W] : m_addr[ADDR_W-1:0];
    win_wdata = win ? m_wdata[2*DATA_W-1 -: DATA_W] : m_wdata[DATA_W-1:0];
  end

  // Region decode of the winning address; descending scan lets the lowest index win
  always_comb begin
    win_hit  = 1'b0;
    win_idx  = '0;
    win_base = '0;
    for (int i = int'(N_SLV) - 1; i >= 0; i--) begin
      if ((win_addr >> SLV_SIZE_LOG2[i*5 +: 5]) ==
          (SLV_BASE[i*ADDR_W +: ADDR_W] >> SLV_SIZE_LOG2[i*5 +: 5])) begin
        win_hit  = 1'b1;
        win_idx  = IDX_W'(i);
        win_base = SLV_BASE[i*ADDR_W +: ADDR_W];
      end
    end
  end

  // Ack and read data of the selected slave only
  always_comb begin
    ack_sel   = 1'b0;
    rdata_sel = '0;
    for (int i = 0; i < int'(N_SLV); i++) begin
      if (idx_q == IDX_W'(i)) begin
        ack_sel   = s_ack[i];
        rdata_sel = s_rdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    we_d      = we_q;
    miss_d    = miss_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    m_ack_d   = 2'b00;
    m_err_d   = 1'b0;
    m_rdata_d = m_rdata;
    s_sel_d   = s_sel;
    s_we_d    = s_we;
    s_addr_d  = s_addr;
    s_wdata_d = s_wdata;
`ifdef ROUND_ROBIN_EN
    rr_d      = rr_q;
`endif
    case (state_q)
      IDLE: begin
        if (m_req != 2'b00) begin
          state_d = ACCESS;
          gnt_d   = win;
          we_d    = win_we;
          miss_d  = ~win_hit;
          idx_d   = win_idx;
          cnt_d   = '0;
`ifdef ROUND_ROBIN_EN
          rr_d    = ~win;
`endif
          if (win_hit) begin
            s_sel_d   = N_SLV'(1) << win_idx;
            s_we_d    = win_we;
            s_addr_d  = ADDR_W'(win_addr - win_base);
            s_wdata_d = win_wdata;
          end else begin
            s_sel_d   = '0;
            s_we_d    = 1'b0;
            s_addr_d  = '0;
            s_wdata_d = '0;
          end
        end
      end
      ACCESS: begin
        if (miss_q) begin
          state_d        = RESP;
          m_ack_d[gnt_q] = 1'b1;
          m_err_d        = 1'b1;
          m_rdata_d      = ERR_DATA;
        end else if (ack_sel) begin
          state_d        = RESP;
          m_ack_d[gnt_q] = 1'b1;
          m_rdata_d      = we_q ? '0 : rdata_sel;
          s_sel_d        = '0;
          s_we_d         = 1'b0;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d        = RESP;
          m_ack_d[gnt_q] = 1'b1;
          m_err_d        = 1'b1;
          m_rdata_d      = ERR_DATA;
          s_sel_d        = '0;
          s_we_d         = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      we_q    <= 1'b0;
      miss_q  <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
      m_ack   <= 2'b00;
      m_err   <= 1'b0;
      m_rdata <= '0;
      s_sel   <= '0;
      s_we    <= 1'b0;
      s_addr  <= '0;
      s_wdata <= '0;
      busy    <= 1'b0;
`ifdef ROUND_ROBIN_EN
      rr_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      miss_q  <= miss_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      m_ack   <= m_ack_d;
      m_err   <= m_err_d;
      m_rdata <= m_rdata_d;
      s_sel   <= s_sel_d;
      s_we    <= s_we_d;
      s_addr  <= s_addr_d;
      s_wdata <= s_wdata_d;
      busy    <= (state_d != IDLE);
`ifdef ROUND_ROBIN_EN
      rr_q    <= rr_d;
`endif
    end
  end

endmodule

// File: tb/tb_mmio_bus_fabric.sv
// Self-checking bench for mmio_bus_fabric: scoreboard of expected responses,
// a configurable slave responder and directed timing checks.
module tb_mmio_bus_fabric;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  m_req = '0;
  logic [1:0]  m_we = '0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_wdata = '0;
  logic [1:0]  m_ack;
  logic        m_err;
  logic [15:0] m_rdata;
  logic [3:0]  s_sel;
  logic        s_we;
  logic [15:0] s_addr;
  logic [15:0] s_wdata;
  logic [63:0] s_rdata = '0;
  logic [3:0]  s_ack = '0;
  logic        busy;

  typedef struct {
    logic [1:0]  ack;
    logic [15:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // responder configuration: ack in the Nth selected cycle (0 = never)
  int          ack_after = 1;
  int          sel_cyc = 0;
  logic        noise = 1'b0;
  logic [15:0] rd_base = '0;

  mmio_bus_fabric dut (
    .clk(clk), .rst(rst),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_err(m_err), .m_rdata(m_rdata),
    .s_sel(s_sel), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_ack(s_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // slave model: slot i returns rd_base+i; noise acks every unselected slave
  always @(negedge clk) begin
    if (rst || s_sel == 4'b0000) begin
      sel_cyc = 0;
      s_ack   = 4'b0000;
    end else begin
      sel_cyc++;
      s_ack = (ack_after != 0 && sel_cyc == ack_after) ? s_sel : 4'b0000;
      if (noise) s_ack = s_ack | ~s_sel;
    end
    for (int i = 0; i < 4; i++) s_rdata[i*16 +: 16] = rd_base + 16'(i);
  end

  // response monitor: every m_ack pulse must match the scoreboard head
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (m_ack != 2'b00) begin
      if (sb.size() == 0) begin
        check_val("unexp_ack", 32'(m_ack), 32'h0);
      end else begin
        e = sb.pop_front();
        check_val("ack_master", 32'(m_ack), 32'(e.ack));
        check_val("rdata", 32'(m_rdata), 32'(e.rdata));
        check_val("err", 32'(m_err), 32'(e.err));
      end
    end else begin
      check_val("err_idle", 32'(m_err), 32'h0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int m, input logic we, input logic [15:0] addr,
                       input logic [15:0] wdata);
    m_we[m]            = we;
    m_addr[m*16 +: 16] = addr;
    m_wdata[m*16 +: 16] = wdata;
    m_req[m]           = 1'b1;
  endtask

  task automatic push(input logic [1:0] ack, input logic [15:0] rdata, input logic err);
    exp_t e;
    e.ack = ack; e.rdata = rdata; e.err = err;
    sb.push_back(e);
  endtask

  task automatic wait_ack(input int budget, output int cyc);
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (m_ack == 2'b00 && cyc < budget);
    check_val("ack_seen", 32'(m_ack != 2'b00), 32'h1);
  endtask

  task automatic finish_txn();
    m_req = 2'b00;
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int c;
    logic [1:0] em;
    step();
    step();
    check_val("rst_m_ack", 32'(m_ack), 32'h0);
    check_val("rst_m_err", 32'(m_err), 32'h0);
    check_val("rst_m_rdata", 32'(m_rdata), 32'h0);
    check_val("rst_s_sel", 32'(s_sel), 32'h0);
    check_val("rst_s_we", 32'(s_we), 32'h0);
    check_val("rst_s_addr", 32'(s_addr), 32'h0);
    check_val("rst_s_wdata", 32'(s_wdata), 32'h0);
    check_val("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    step();

    // zero-wait read from slave 1
    rd_base = 16'h1233; ack_after = 1;
    drive(0, 1'b0, 16'h2005, 16'h0000);
    push(2'b01, 16'h1234, 1'b0);
    step();
    check_val("zw_s_sel", 32'(s_sel), 32'h2);
    check_val("zw_s_addr", 32'(s_addr), 32'h5);
    check_val("zw_no_ack_yet", 32'(m_ack), 32'h0);
    wait_ack(20, c);
    check_val("zw_latency", 32'(c), 32'd1);
    finish_txn();

    // wait-state write to slave 3
    ack_after = 4;
    drive(1, 1'b1, 16'h4803, 16'h00FF);
    push(2'b10, 16'h0000, 1'b0);
    step();
    check_val("wr_s_sel", 32'(s_sel), 32'h8);
    check_val("wr_s_we", 32'(s_we), 32'h1);
    check_val("wr_s_addr", 32'(s_addr), 32'h3);
    check_val("wr_s_wdata", 32'(s_wdata), 32'h00FF);
    wait_ack(20, c);
    check_val("wr_latency", 32'(c), 32'd4);
    check_val("wr_s_we_drop", 32'(s_we), 32'h0);
    finish_txn();

    // unmapped address
    ack_after = 1;
    drive(0, 1'b0, 16'hF000, 16'h0000);
    push(2'b01, 16'hDEAD, 1'b1);
    step();
    check_val("um_s_sel", 32'(s_sel), 32'h0);
    check_val("um_busy", 32'(busy), 32'h1);
    wait_ack(20, c);
    check_val("um_latency", 32'(c), 32'd1);
    finish_txn();

    // timeout with unselected slaves acking
    ack_after = 0; noise = 1'b1;
    drive(0, 1'b0, 16'h0010, 16'h0000);
    push(2'b01, 16'hDEAD, 1'b1);
    step();
    check_val("to_s_sel", 32'(s_sel), 32'h1);
    wait_ack(40, c);
    check_val("to_latency", 32'(c), 32'd15);
    check_val("to_s_sel_drop", 32'(s_sel), 32'h0);
    finish_txn();
    check_val("to_busy_idle", 32'(busy), 32'h0);
    noise = 1'b0;

    // contention: both masters request continuously
    do_reset();
    ack_after = 1; rd_base = 16'h5A00;
    drive(0, 1'b0, 16'h2000, 16'h0000);
    drive(1, 1'b0, 16'h0001, 16'h0000);
    for (int k = 0; k < 4; k++) begin
`ifdef ROUND_ROBIN_EN
      em = (k % 2 == 0) ? 2'b01 : 2'b10;
`else
      em = 2'b01;
`endif
      push(em, (em == 2'b01) ? 16'h5A01 : 16'h5A00, 1'b0);
    end
    for (int k = 0; k < 4; k++) begin
      wait_ack(20, c);
      check_val("ct_turnaround", 32'(c), (k == 0) ? 32'd2 : 32'd3);
    end
    finish_txn();

    // reset while slave 2 is waiting for ack
    do_reset();
    ack_after = 0;
    drive(0, 1'b0, 16'h4400, 16'h0000);
    step();
    check_val("ra_s_sel", 32'(s_sel), 32'h4);
    step();
    step();
    rst = 1'b1;
    step();
    check_val("ra_s_sel", 32'(s_sel), 32'h0);
    check_val("ra_busy", 32'(busy), 32'h0);
    check_val("ra_m_ack", 32'(m_ack), 32'h0);
    check_val("ra_s_we", 32'(s_we), 32'h0);
    rst = 1'b0;
    m_req = 2'b00;
    repeat (4) step();
    check_val("sb_empty", 32'(sb.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
